// File: rtl/complex_div_operand_collector.sv
// Collects four serial IEEE-754 beats (a.re, a.im, b.re, b.im) into one operand bundle for the complex divider.
// Latency: the bundle is valid one cycle after its final beat is accepted.
// Backpressure: only the completing beat waits on a stalled output; earlier beats are always taken.
module complex_div_operand_collector #(
    parameter int NUM_OPERANDS = 4,
    parameter int WIDTH        = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                flush_i,
    input  logic                                word_valid_i,
    output logic                                word_ready_o,
    input  logic [WIDTH-1:0]                    word_i,
    input  logic                                word_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]  operands_o,
    output logic                                div_zero_o,
    output logic                                frame_err_o,
    output logic                                busy_o
);

    localparam int CW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPERANDS - 1);

    logic [CW-1:0]                         cnt;
    logic [CW-1:0]                         cnt_nxt;
    logic [NUM_OPERANDS-2:0][WIDTH-1:0]    slots;
    logic                                  out_vld_nxt;
    logic                                  frame_err_nxt;
    logic                                  at_last;
    logic                                  accept;
    logic                                  framing_bad;
    logic                                  complete;
    logic                                  xfer;

    assign at_last      = (cnt == LAST_IDX);
    // Only the completing beat needs a free output register.
    assign word_ready_o = rst_ni && !flush_i && !(at_last && out_valid_o && !out_ready_i);
    assign accept       = word_valid_i && word_ready_o;
    assign framing_bad  = accept && (word_last_i != at_last);
    assign complete     = accept && at_last && word_last_i;
    assign xfer         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_nxt       = cnt;
        out_vld_nxt   = out_valid_o;
        frame_err_nxt = 1'b0;
        if (flush_i) begin
            cnt_nxt     = '0;
            out_vld_nxt = 1'b0;
        end else begin
            if (accept) begin
                cnt_nxt = (at_last || framing_bad) ? '0 : cnt + 1'b1;
            end
            frame_err_nxt = framing_bad;
            if (complete) begin
                out_vld_nxt = 1'b1;
            end else if (xfer) begin
                out_vld_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt         <= '0;
            slots       <= '0;
            out_valid_o <= 1'b0;
            operands_o  <= '0;
            div_zero_o  <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            out_valid_o <= out_vld_nxt;
            frame_err_o <= frame_err_nxt;
            busy_o      <= (cnt_nxt != '0) || out_vld_nxt;
            if (accept && !framing_bad) begin
                if (at_last) begin
                    for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
                        operands_o[i] <= slots[i];
                    end
                    operands_o[NUM_OPERANDS-1] <= word_i;
                    // Sign bit ignored: +0 and -0 both count as zero.
                    div_zero_o <= (slots[NUM_OPERANDS-2][WIDTH-2:0] == '0) &&
                                  (word_i[WIDTH-2:0] == '0);
                end else begin
                    for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
                        if (cnt == CW'(i)) begin
                            slots[i] <= word_i;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_div_operand_collector.sv
// Directed bench for complex_div_operand_collector with hand-computed expectations.
module tb_complex_div_operand_collector;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              word_vld;
    logic              word_rdy;
    logic [63:0]       word_dat;
    logic              word_last;
    logic              out_vld;
    logic              out_rdy;
    logic [3:0][63:0]  operands;
    logic              div_zero;
    logic              frame_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    complex_div_operand_collector #(.NUM_OPERANDS(4), .WIDTH(64)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .word_valid_i (word_vld),
        .word_ready_o (word_rdy),
        .word_i       (word_dat),
        .word_last_i  (word_last),
        .out_valid_o  (out_vld),
        .out_ready_i  (out_rdy),
        .operands_o   (operands),
        .div_zero_o   (div_zero),
        .frame_err_o  (frame_err),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for a single cycle, then drop valid.
    task automatic send(input logic [63:0] w, input logic last);
        word_vld  = 1'b1;
        word_dat  = w;
        word_last = last;
        tick();
        word_vld  = 1'b0;
        word_last = 1'b0;
    endtask

    task automatic send4(input logic [63:0] w0, input logic [63:0] w1,
                         input logic [63:0] w2, input logic [63:0] w3);
        send(w0, 1'b0);
        send(w1, 1'b0);
        send(w2, 1'b0);
        send(w3, 1'b1);
    endtask

    task automatic expect_bundle(input string tag, input logic [63:0] w0, input logic [63:0] w1,
                                 input logic [63:0] w2, input logic [63:0] w3, input logic dz);
        check({tag, ".vld"}, 64'(out_vld), 64'd1);
        check({tag, ".op0"}, operands[0], w0);
        check({tag, ".op1"}, operands[1], w1);
        check({tag, ".op2"}, operands[2], w2);
        check({tag, ".op3"}, operands[3], w3);
        check({tag, ".dz"},  64'(div_zero), 64'(dz));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; word_vld = 1'b0; word_dat = '0;
        word_last = 1'b0; out_rdy = 1'b0;
        tick(); tick();
        word_vld = 1'b1;
        #1;
        check("rst.ready", 64'(word_rdy), 64'd0);
        check("rst.vld",   64'(out_vld), 64'd0);
        check("rst.busy",  64'(busy), 64'd0);
        check("rst.ferr",  64'(frame_err), 64'd0);
        check("rst.ops",   operands[0] | operands[3], 64'd0);
        word_vld = 1'b0;
        tick();
        rst_n = 1'b1;

        // Basic bundle, divider ready.
        out_rdy = 1'b1;
        send(64'h4008000000000000, 1'b0);
        check("t1.busy_b0", 64'(busy), 64'd1);
        check("t1.vld_b0",  64'(out_vld), 64'd0);
        send(64'h0000000000000000, 1'b0);
        send(64'h4000000000000000, 1'b0);
        check("t1.vld_b2",  64'(out_vld), 64'd0);
        send(64'h3FF0000000000000, 1'b1);
        expect_bundle("t1", 64'h4008000000000000, 64'h0, 64'h4000000000000000,
                      64'h3FF0000000000000, 1'b0);
        check("t1.busy_out", 64'(busy), 64'd1);
        tick();
        check("t1.vld_done",  64'(out_vld), 64'd0);
        check("t1.busy_done", 64'(busy), 64'd0);

        // Signed-zero divisor, then a denormal divisor that must not count as zero.
        send4(64'h3FF0000000000000, 64'h0, 64'h8000000000000000, 64'h0);
        expect_bundle("t2z", 64'h3FF0000000000000, 64'h0, 64'h8000000000000000, 64'h0, 1'b1);
        tick();
        send4(64'h1, 64'h2, 64'h0000000000000001, 64'h8000000000000000);
        expect_bundle("t2d", 64'h1, 64'h2, 64'h0000000000000001, 64'h8000000000000000, 1'b0);
        tick();

        // Stall: first bundle holds, second collects up to its last beat.
        out_rdy = 1'b0;
        send4(64'hB0, 64'hB1, 64'hB2, 64'hB3);
        expect_bundle("t3b", 64'hB0, 64'hB1, 64'hB2, 64'hB3, 1'b0);
        send(64'hC0, 1'b0);
        send(64'hC1, 1'b0);
        send(64'hC2, 1'b0);
        expect_bundle("t3hold", 64'hB0, 64'hB1, 64'hB2, 64'hB3, 1'b0);
        word_vld = 1'b1; word_dat = 64'hC3; word_last = 1'b1;
        #1;
        check("t3.rdy_stall", 64'(word_rdy), 64'd0);
        tick();
        check("t3.rdy_stall2", 64'(word_rdy), 64'd0);
        check("t3.hold_op3", operands[3], 64'hB3);
        out_rdy = 1'b1;
        #1;
        check("t3.rdy_go", 64'(word_rdy), 64'd1);
        tick();
        word_vld = 1'b0; word_last = 1'b0;
        expect_bundle("t3c", 64'hC0, 64'hC1, 64'hC2, 64'hC3, 1'b0);
        tick();
        check("t3.vld_done", 64'(out_vld), 64'd0);

        // Framing errors: early last, then missing last; then a good bundle.
        send(64'hD0, 1'b0);
        send(64'hD1, 1'b1);
        check("t4.ferr",   64'(frame_err), 64'd1);
        check("t4.vld",    64'(out_vld), 64'd0);
        check("t4.busy",   64'(busy), 64'd0);
        tick();
        check("t4.ferr_pulse", 64'(frame_err), 64'd0);
        send(64'hD0, 1'b0);
        send(64'hD1, 1'b0);
        send(64'hD2, 1'b0);
        send(64'hD3, 1'b0);
        check("t4.ferr_nolast", 64'(frame_err), 64'd1);
        check("t4.vld_nolast",  64'(out_vld), 64'd0);
        send4(64'hE0, 64'hE1, 64'hE2, 64'hE3);
        check("t4.ferr_ok", 64'(frame_err), 64'd0);
        expect_bundle("t4e", 64'hE0, 64'hE1, 64'hE2, 64'hE3, 1'b0);
        tick();

        // Flush with a stalled bundle and two beats collected.
        out_rdy = 1'b0;
        send4(64'hF0, 64'hF1, 64'hF2, 64'hF3);
        send(64'hA0, 1'b0);
        send(64'hA1, 1'b0);
        flush = 1'b1; word_vld = 1'b1; word_dat = 64'hA2; out_rdy = 1'b1;
        #1;
        check("t5.rdy_flush", 64'(word_rdy), 64'd0);
        tick();
        flush = 1'b0; word_vld = 1'b0;
        check("t5.vld",  64'(out_vld), 64'd0);
        check("t5.busy", 64'(busy), 64'd0);
        check("t5.ferr", 64'(frame_err), 64'd0);
        send4(64'h10, 64'h11, 64'h12, 64'h13);
        expect_bundle("t5h", 64'h10, 64'h11, 64'h12, 64'h13, 1'b0);
        tick();

        // Reset mid-bundle with a pending output.
        out_rdy = 1'b0;
        send4(64'h20, 64'h21, 64'h22, 64'h0);
        send(64'h30, 1'b0);
        send(64'h31, 1'b0);
        send(64'h32, 1'b0);
        rst_n = 1'b0; word_vld = 1'b1; word_dat = 64'h33; word_last = 1'b1;
        #1;
        check("t6.rdy_rst", 64'(word_rdy), 64'd0);
        tick();
        word_vld = 1'b0; word_last = 1'b0;
        check("t6.vld",  64'(out_vld), 64'd0);
        check("t6.busy", 64'(busy), 64'd0);
        check("t6.op0",  operands[0], 64'd0);
        check("t6.op3",  operands[3], 64'd0);
        rst_n = 1'b1; out_rdy = 1'b1;
        send4(64'h40, 64'h41, 64'h42, 64'h43);
        expect_bundle("t6j", 64'h40, 64'h41, 64'h42, 64'h43, 1'b0);
        tick();
        check("t6.vld_done", 64'(out_vld), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/complex_div_operand_collector.md
Name: complex_div_operand_collector

Overview:
- Upstream issue stage for the complex divider.
- Accepts a serial stream of WIDTH-bit IEEE-754 words, four beats per complex division in the order a.re, a.im, b.re, b.im.
- Assembles each group of beats into the NUM_OPERANDS x WIDTH operand bundle and presents it to the divider over a valid/ready handshake.
- Checks framing and flags a zero divisor; supports flush and reports busy, matching the divider's control interface.

Parameters:
- NUM_OPERANDS, 4, beats per bundle; index 0 = a.re, 1 = a.im, 2 = b.re, 3 = b.im.
- WIDTH, 64, bits per operand word (IEEE-754 binary64 at default).

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  synchronous active-low reset.
- flush_i  input  1  discard partial and pending bundles.
- word_valid_i  input  1  upstream word valid.
- word_ready_o  output  1  collector can accept a word.
- word_i  input  WIDTH  operand word.
- word_last_i  input  1  marks the final beat of a bundle.
- out_valid_o  output  1  bundle valid toward the divider (drives divider in_valid_i).
- out_ready_i  input  1  divider ready (from divider in_ready_o).
- operands_o  output  [NUM_OPERANDS-1:0][WIDTH-1:0]  assembled bundle.
- div_zero_o  output  1  divisor is +/-0 in both parts; valid with out_valid_o.
- frame_err_o  output  1  one-cycle pulse on a framing error.
- busy_o  output  1  partial bundle held or output pending.

Behaviour:
- Reset is synchronous on rst_ni=0 and clears all state:
  - beat counter cnt=0, assembly regs=0;
  - out_valid_o=0, operands_o=0, div_zero_o=0, frame_err_o=0, busy_o=0;
  - word_ready_o=0 while rst_ni=0.
- Reset mid-bundle drops all collected beats. No outputs are produced from pre-reset data.
- A word is accepted when word_valid_i && word_ready_o.
- An accepted word at cnt<NUM_OPERANDS-1:
  - stores into assembly slot cnt;
  - cnt increments.
- An accepted word at cnt==NUM_OPERANDS-1:
  - loads operands_o from slots 0..N-2 plus word_i into the top slot;
  - sets out_valid_o=1 on the next cycle;
  - resets cnt to 0.
- Latency: the bundle is visible one cycle after the final beat is accepted.
- Throughput: one bundle per NUM_OPERANDS cycles with no bubbles while downstream is ready.
- Ready rule: word_ready_o = rst_ni && !flush_i && !(cnt==NUM_OPERANDS-1 && out_valid_o && !out_ready_i).
  - Beats 0..N-2 are always accepted, even while an output is stalled.
  - Only the completing beat waits on the output register.
- Output handshake:
  - out_valid_o stays high and operands_o/div_zero_o stay stable until out_valid_o && out_ready_i.
  - On that transfer, out_valid_o clears next cycle unless a new bundle completes in the same cycle; in that case it stays 1 with the new data (back-to-back).
- div_zero_o: registered with the bundle; 1 iff word bits [WIDTH-2:0]==0 for both slot 2 and slot 3. The sign bit is ignored, and NaN/denormal are treated as non-zero.
- Framing, checked on every accepted word:
  - Error cases: word_last_i=1 with cnt!=NUM_OPERANDS-1, or word_last_i=0 with cnt==NUM_OPERANDS-1.
  - On error: the word is consumed, cnt returns to 0, partial assembly is discarded, no bundle is produced, and frame_err_o pulses high for the next cycle only.
  - A pending out_valid_o bundle is unaffected.
- flush_i=1 (highest priority after reset):
  - next cycle: cnt=0 and out_valid_o=0;
  - any pending bundle is dropped even if out_ready_i is high that cycle;
  - no word is accepted in the flush cycle;
  - frame_err_o is not raised.
- busy_o = (cnt!=0) || out_valid_o, registered form.
- Simultaneous output transfer and final-beat accept in the same cycle is legal and lossless.

Test Plan:
- Reset, then stream 4008000000000000, 0000000000000000, 4000000000000000, 3FF0000000000000 (last on beat 3) with out_ready_i=1 -> out_valid_o high one cycle after beat 3 with operands_o[0..3] matching, div_zero_o=0; busy_o high from beat 1 until transfer.
- Divisor beats 8000000000000000 and 0000000000000000 -> div_zero_o=1 with the bundle.
- Hold out_ready_i=0 and send two bundles back to back:
  - the first bundle holds stable;
  - beats 0-2 of the second are accepted;
  - word_ready_o drops at beat 3;
  - after out_ready_i=1, the first transfers and the second appears the next cycle, with no loss or duplication.
- word_last_i=1 on beat 1 -> frame_err_o one-cycle pulse, no bundle; a following correct 4-beat bundle is delivered intact.
- Assert flush_i with 2 beats collected and a stalled bundle pending -> out_valid_o=0, busy_o=0 next cycle, word_ready_o=0 in the flush cycle; the next bundle assembles from beat 0.
- Deassert rst_ni mid-bundle (after beat 2) -> all outputs zero on the following edge; a subsequent full bundle is collected correctly.
